// File: rtl/fir_128_mdc_tcdm_responder_pkg.sv
// Shared constants and types for the FIR-128 MDC TCDM responder.
// Holds the out-of-range read pattern, stall LFSR constants and the response bundle.
package fir_128_mdc_package;

   localparam logic [31:0] TCDM_OOR_RDATA = 32'hDEAD_BEEF;

   // Fibonacci taps 16,14,13,11 as a mask over lfsr[15:0]
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   typedef struct packed {
      logic        r_valid;
      logic [31:0] r_data;
   } tcdm_resp_t;

endpackage

// File: rtl/hwpe_stream_intf_tcdm.sv
// TCDM request/response channel between a master and a memory responder.
// Signals: req, gnt, add, wen (1=read), be, data, r_data, r_valid.
interface hwpe_stream_intf_tcdm;

   logic        req;
   logic        gnt;
   logic [31:0] add;
   logic        wen;
   logic [3:0]  be;
   logic [31:0] data;
   logic [31:0] r_data;
   logic        r_valid;

   modport master (
      output req, add, wen, be, data,
      input  gnt, r_data, r_valid
   );

   modport slave (
      input  req, add, wen, be, data,
      output gnt, r_data, r_valid
   );

endinterface

// File: rtl/fir_128_mdc_tcdm_responder_lfsr.sv
// Per-port stall generator: 16-bit Fibonacci LFSR, stall_o = lfsr[0].
// Ports: clk_i, rst_i (async, high), clear_i (sync reload), stall_o.
module fir_128_mdc_tcdm_lfsr
   import fir_128_mdc_package::*;
#(
   parameter logic [15:0] SEED = LFSR_SEED
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clear_i,
   output logic stall_o
);

   logic [15:0] lfsr_q, lfsr_d;

   always_comb begin
      lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
      if (clear_i) lfsr_d = SEED;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) lfsr_q <= SEED;
      else       lfsr_q <= lfsr_d;
   end

   assign stall_o = lfsr_q[0];

endmodule

// File: rtl/fir_128_mdc_tcdm_responder.sv
// Multi-ported TCDM memory responder with byte-enable writes, 1-cycle read
// latency, saturating access counters and a sticky out-of-range flag.
// Ports: clk_i, rst_i (async, high), clear_i, tcdm[MP] (slave),
//        n_reads_o, n_writes_o, err_o.
// Macro FIR_128_MDC_TCDM_STALL_INJECT_EN adds per-port random grant stalls.
module fir_128_mdc_tcdm_responder
   import fir_128_mdc_package::*;
#(
   parameter int unsigned MP        = 2,
   parameter int unsigned N_WORDS   = 1024,
   parameter logic [31:0] BASE_ADDR = 32'h0
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 clear_i,
   hwpe_stream_intf_tcdm.slave  tcdm [MP-1:0],
   output logic [31:0]          n_reads_o,
   output logic [31:0]          n_writes_o,
   output logic                 err_o
);

   localparam int unsigned AW = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;

   logic [MP-1:0] req, wen, gnt, stall, oor, rd_ok, wr_ok;
   logic [31:0]   add   [MP];
   logic [31:0]   wdata [MP];
   logic [3:0]    be    [MP];
   logic [31:0]   word  [MP];
   logic [AW-1:0] idx   [MP];

   tcdm_resp_t resp_d [MP];
   tcdm_resp_t resp_q [MP];

   logic [31:0] n_reads_d, n_reads_q;
   logic [31:0] n_writes_d, n_writes_q;
   logic        err_d, err_q;
   logic [32:0] rd_sum, wr_sum;

   logic [31:0] mem_q [N_WORDS];

   for (genvar g = 0; g < MP; g++) begin : g_port
      assign req[g]   = tcdm[g].req;
      assign wen[g]   = tcdm[g].wen;
      assign add[g]   = tcdm[g].add;
      assign be[g]    = tcdm[g].be;
      assign wdata[g] = tcdm[g].data;

      assign tcdm[g].gnt     = gnt[g];
      assign tcdm[g].r_valid = resp_q[g].r_valid;
      assign tcdm[g].r_data  = resp_q[g].r_data;

`ifdef FIR_128_MDC_TCDM_STALL_INJECT_EN
      fir_128_mdc_tcdm_lfsr #(
         .SEED (LFSR_SEED ^ 16'(g))
      ) u_lfsr (
         .clk_i   (clk_i),
         .rst_i   (rst_i),
         .clear_i (clear_i),
         .stall_o (stall[g])
      );
`else
      assign stall[g] = 1'b0;
`endif
   end

   assign gnt = req & ~stall;

   always_comb begin
      rd_sum = {1'b0, n_reads_q};
      wr_sum = {1'b0, n_writes_q};
      err_d  = err_q;
      for (int p = 0; p < MP; p++) begin
         word[p]  = (add[p] - BASE_ADDR) >> 2;
         oor[p]   = (add[p] < BASE_ADDR) || (word[p] >= 32'(N_WORDS));
         idx[p]   = word[p][AW-1:0];
         rd_ok[p] = gnt[p] & wen[p] & ~oor[p];
         wr_ok[p] = gnt[p] & ~wen[p] & ~oor[p];
         rd_sum   = rd_sum + 33'(rd_ok[p]);
         wr_sum   = wr_sum + 33'(wr_ok[p]);
         if (gnt[p] && oor[p]) err_d = 1'b1;

         // mem_q is sampled before this edge's writes: read-before-write
         resp_d[p] = '0;
         if (gnt[p] && !clear_i) begin
            resp_d[p].r_valid = 1'b1;
            if (wen[p])
               resp_d[p].r_data = oor[p] ? TCDM_OOR_RDATA : mem_q[idx[p]];
         end
      end
      n_reads_d  = rd_sum[32] ? '1 : rd_sum[31:0];
      n_writes_d = wr_sum[32] ? '1 : wr_sum[31:0];
      if (clear_i) begin
         n_reads_d  = '0;
         n_writes_d = '0;
         err_d      = 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         n_reads_q  <= '0;
         n_writes_q <= '0;
         err_q      <= 1'b0;
         for (int p = 0; p < MP; p++) resp_q[p] <= '0;
      end else begin
         n_reads_q  <= n_reads_d;
         n_writes_q <= n_writes_d;
         err_q      <= err_d;
         for (int p = 0; p < MP; p++) resp_q[p] <= resp_d[p];
      end
   end

   // Highest port first so lower ports overwrite shared bytes last
   always_ff @(posedge clk_i) begin
      for (int p = MP - 1; p >= 0; p--) begin
         if (wr_ok[p]) begin
            for (int b = 0; b < 4; b++) begin
               if (be[p][b]) mem_q[idx[p]][8*b +: 8] <= wdata[p][8*b +: 8];
            end
         end
      end
   end

   assign n_reads_o  = n_reads_q;
   assign n_writes_o = n_writes_q;
   assign err_o      = err_q;

endmodule

// File: tb/tb_fir_128_mdc_tcdm_responder.sv
// Directed bench for fir_128_mdc_tcdm_responder.
// With FIR_128_MDC_TCDM_STALL_INJECT_EN it runs a stalled read stress instead.
module tb_fir_128_mdc_tcdm_responder;

   localparam int          MP = 2;
   localparam int          NW = 1024;
   localparam logic [31:0] B  = 32'h0000_1000;

   logic clk = 1'b0;
   logic rst;
   logic clear;
   logic [31:0] n_reads, n_writes;
   logic err;

   logic [MP-1:0] req, wen, gnt, rv;
   logic [31:0]   add  [MP];
   logic [31:0]   data [MP];
   logic [3:0]    be   [MP];
   logic [31:0]   rd   [MP];

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   hwpe_stream_intf_tcdm tcdm [MP-1:0] ();

   for (genvar g = 0; g < MP; g++) begin : g_drv
      assign tcdm[g].req  = req[g];
      assign tcdm[g].wen  = wen[g];
      assign tcdm[g].add  = add[g];
      assign tcdm[g].be   = be[g];
      assign tcdm[g].data = data[g];
      assign gnt[g] = tcdm[g].gnt;
      assign rv[g]  = tcdm[g].r_valid;
      assign rd[g]  = tcdm[g].r_data;
   end

   fir_128_mdc_tcdm_responder #(
      .MP        (MP),
      .N_WORDS   (NW),
      .BASE_ADDR (B)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .clear_i    (clear),
      .tcdm       (tcdm),
      .n_reads_o  (n_reads),
      .n_writes_o (n_writes),
      .err_o      (err)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   task automatic idle();
      for (int p = 0; p < MP; p++) begin
         req[p]  = 1'b0;
         wen[p]  = 1'b1;
         add[p]  = '0;
         be[p]   = '0;
         data[p] = '0;
      end
   endtask

   task automatic set_rd(input int p, input logic [31:0] a);
      req[p] = 1'b1; wen[p] = 1'b1; add[p] = a; be[p] = '0; data[p] = '0;
   endtask

   task automatic set_wr(input int p, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] b);
      req[p] = 1'b1; wen[p] = 1'b0; add[p] = a; be[p] = b; data[p] = d;
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

`ifdef FIR_128_MDC_TCDM_STALL_INJECT_EN
   int grants [MP];

   task automatic wait_gnt(input int p);
      int n = 0;
      @(negedge clk); #1;
      while (!gnt[p] && n < 100) begin
         @(negedge clk); #1;
         n++;
      end
      if (!gnt[p]) chk("gnt_timeout", 32'(gnt[p]), 32'd1);
      @(posedge clk); #1;
   endtask

   task automatic stress(input int p);
      logic        pend = 1'b0;
      logic [31:0] exp_d = '0;
      int          k = 0;
      int          cyc = 0;
      logic        took;
      set_rd(p, B + 32'(4 * (k % 8)));
      while (k < 1000 && cyc < 20000) begin
         @(negedge clk); #1;
         cyc++;
         chk("stress_rv", 32'(rv[p]), 32'(pend));
         if (pend) chk("stress_rd", rd[p], 32'hA5A5_0000 + 32'(exp_d));
         pend = 1'b0;
         took = gnt[p];
         if (took) begin
            pend  = 1'b1;
            exp_d = 32'(k % 8);
            grants[p]++;
         end
         @(posedge clk); #1;
         if (took) begin
            k++;
            if (k < 1000) set_rd(p, B + 32'(4 * (k % 8)));
            else          req[p] = 1'b0;
         end
      end
      chk("stress_done", 32'(k), 32'd1000);
      @(negedge clk); #1;
      chk("stress_rv_last", 32'(rv[p]), 32'(pend));
      if (pend) chk("stress_rd_last", rd[p], 32'hA5A5_0000 + 32'(exp_d));
   endtask
`endif

   initial begin
      rst   = 1'b1;
      clear = 1'b0;
      idle();
      set_rd(0, B);
      repeat (2) @(negedge clk);
      #1;
`ifndef FIR_128_MDC_TCDM_STALL_INJECT_EN
      chk("rst_gnt", 32'(gnt[0]), 32'd1);
`endif
      chk("rst_rv0", 32'(rv[0]), 32'd0);
      chk("rst_rd0", rd[0], 32'd0);
      chk("rst_nr", n_reads, 32'd0);
      chk("rst_nw", n_writes, 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      idle();
      rst = 1'b0;
      tick();

`ifdef FIR_128_MDC_TCDM_STALL_INJECT_EN
      for (int w = 0; w < 8; w++) begin
         set_wr(0, B + 32'(4 * w), 32'hA5A5_0000 + 32'(w), 4'hF);
         wait_gnt(0);
         idle();
      end
      @(negedge clk);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      grants[0] = 0;
      grants[1] = 0;
      fork
         stress(0);
         stress(1);
      join
      @(negedge clk);
      chk("stress_nr", n_reads, 32'(grants[0] + grants[1]));
      chk("stress_err", 32'(err), 32'd0);
`else
      // write then read back from the other port
      set_wr(0, B + 8, 32'h1234_5678, 4'hF);
      #1;
      chk("wr_gnt", 32'(gnt[0]), 32'd1);
      tick();
      idle();
      chk("wr_rv", 32'(rv[0]), 32'd1);
      chk("wr_rd", rd[0], 32'd0);
      chk("wr_nw", n_writes, 32'd1);
      chk("wr_nr", n_reads, 32'd0);
      set_rd(1, B + 8);
      tick();
      idle();
      chk("rd_rv", 32'(rv[1]), 32'd1);
      chk("rd_data", rd[1], 32'h1234_5678);
      chk("rd_rv0", 32'(rv[0]), 32'd0);
      chk("rd_nr", n_reads, 32'd1);
      tick();
      chk("rd_rv_drop", 32'(rv[1]), 32'd0);

      // same-word writes, lowest port wins per byte
      set_wr(0, B + 16, 32'hAAAA_AAAA, 4'h3);
      set_wr(1, B + 16, 32'h5555_5555, 4'hF);
      tick();
      idle();
      set_rd(0, B + 16);
      tick();
      idle();
      chk("coll_wr", rd[0], 32'h5555_AAAA);

      set_wr(0, B + 20, 32'h1122_3344, 4'hF);
      tick();
      set_wr(0, B + 20, 32'hAABB_CCDD, 4'h5);
      idle();
      set_wr(1, B + 20, 32'hAABB_CCDD, 4'h5);
      tick();
      idle();
      set_rd(0, B + 20);
      tick();
      idle();
      chk("be_merge", rd[0], 32'h11BB_33DD);
      chk("cnt_nw5", n_writes, 32'd5);
      chk("cnt_nr3", n_reads, 32'd3);

      // last in-range word, low address bits ignored
      set_wr(0, B + 32'(4 * (NW - 1)), 32'hCAFE_F00D, 4'hF);
      tick();
      idle();
      set_rd(1, B + 32'(4 * (NW - 1)) + 3);
      tick();
      idle();
      chk("last_word", rd[1], 32'hCAFE_F00D);
      chk("last_err", 32'(err), 32'd0);

      // out of range above and below
      set_rd(1, B + 32'(4 * NW));
      tick();
      idle();
      chk("oor_hi_rd", rd[1], 32'hDEAD_BEEF);
      chk("oor_hi_rv", 32'(rv[1]), 32'd1);
      chk("oor_err", 32'(err), 32'd1);
      chk("oor_nr", n_reads, 32'd4);
      tick();
      chk("oor_sticky", 32'(err), 32'd1);
      set_rd(0, B - 4);
      set_wr(1, 32'h0000_0010, 32'h0BAD_0BAD, 4'hF);
      tick();
      idle();
      chk("oor_lo_rd", rd[0], 32'hDEAD_BEEF);
      chk("oor_wr_rd", rd[1], 32'd0);
      chk("oor_wr_nw", n_writes, 32'd6);

      // clear wins over a same-cycle read
      clear = 1'b1;
      set_rd(0, B + 8);
      tick();
      clear = 1'b0;
      idle();
      chk("clr_err", 32'(err), 32'd0);
      chk("clr_nr", n_reads, 32'd0);
      chk("clr_nw", n_writes, 32'd0);
      chk("clr_rv", 32'(rv[0]), 32'd0);

      // read-before-write on a same-cycle collision
      set_wr(0, B + 24, 32'h0, 4'hF);
      tick();
      set_wr(0, B + 24, 32'hFFFF_FFFF, 4'hF);
      set_rd(1, B + 24);
      tick();
      idle();
      chk("rbw_old", rd[1], 32'h0);
      set_rd(1, B + 24);
      tick();
      idle();
      chk("rbw_new", rd[1], 32'hFFFF_FFFF);
      chk("rbw_nw", n_writes, 32'd2);
      chk("rbw_nr", n_reads, 32'd2);

      // reset right after a granted read
      set_rd(0, B + 8);
      @(posedge clk);
      #1;
      rst = 1'b1;
      idle();
      @(negedge clk);
      chk("rst_pend_rv", 32'(rv[0]), 32'd0);
      chk("rst_pend_nr", n_reads, 32'd0);
      chk("rst_pend_nw", n_writes, 32'd0);
      tick();
      rst = 1'b0;
      tick();
      chk("rst_rel_rv", 32'(rv[0]), 32'd0);
      tick();
      chk("rst_rel_rv2", 32'(rv[0]), 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
